// File: rtl/daq_pkg.sv
// rtl/daq_pkg.sv - shared capture-state encodings and default frame geometry for the DAQ path
package daq_pkg;

    // One-hot capture state as seen by the DAQ sampler.
    localparam logic [2:0] DAQ_IDLE  = 3'b000;
    localparam logic [2:0] DAQ_FOT   = 3'b001;
    localparam logic [2:0] DAQ_WR_EN = 3'b010;
    localparam logic [2:0] DAQ_ROT   = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE  = DAQ_IDLE,
        S_FOT   = DAQ_FOT,
        S_WR_EN = DAQ_WR_EN,
        S_ROT   = DAQ_ROT
    } daq_state_t;

    // Default sensor geometry.
    localparam int EXP_PIX_DEF   = 608;
    localparam int EXP_LINES_DEF = 608;

endpackage

// File: rtl/daq_edge_det.sv
// rtl/daq_edge_det.sv - one-stage delay register with rise/fall pulses for a sync level input
module daq_edge_det #(
    // Delayed copy comes out of reset as if the input had been high, so a
    // level that is already high at reset release never looks like a rise.
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic rise,
    output logic fall
);
    logic x_d;

    // Delay the input by one clock for edge comparison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) x_d <= RST_VAL;
        else     x_d <= x;
    end

    assign rise = x & ~x_d;
    assign fall = ~x & x_d;
endmodule

// File: rtl/daq_frame_ctrl.sv
// rtl/daq_frame_ctrl.sv - frame/line capture sequencer with pixel/line counting and size checks
module daq_frame_ctrl
    import daq_pkg::*;
#(
    parameter int PIX_W     = 12,
    parameter int LINE_W    = 11,
    parameter int FCNT_W    = 16,
    parameter int EXP_PIX   = EXP_PIX_DEF,
    parameter int EXP_LINES = EXP_LINES_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              capture_en,
    input  logic              frame_vaild,
    input  logic              line_vaild,
    input  logic              err_clr,
    output logic [2:0]        state,
    output logic              frame_start,
    output logic              frame_done,
    output logic              line_done,
    output logic [PIX_W-1:0]  line_pix,
    output logic [LINE_W-1:0] line_cnt,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              err_line_len,
    output logic              err_frame_len
);
    logic fv_rise, fv_fall, lv_rise, lv_fall;

    daq_edge_det u_fv_edge (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .x    (frame_vaild),
        .rise (fv_rise),
        .fall (fv_fall)
    );

    daq_edge_det u_lv_edge (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .x    (line_vaild),
        .rise (lv_rise),
        .fall (lv_fall)
    );

    daq_state_t        state_q, state_nxt;
    logic [PIX_W-1:0]  pix_q, pix_nxt, pix_inc;
    logic [PIX_W-1:0]  line_pix_q, line_pix_nxt;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_nxt, line_inc, lines_at_end;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_nxt;
    logic              fs_q, fs_nxt, fd_q, fd_nxt, ld_q, ld_nxt;
    logic              err_line_q, err_frame_q, set_line, set_frame;

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state_q <= S_IDLE;
        else         state_q <= state_nxt;
    end

    // Next state, counter updates and pulse/error-set decisions.
    always_comb begin
        state_nxt     = state_q;
        pix_nxt       = pix_q;
        line_pix_nxt  = line_pix_q;
        line_cnt_nxt  = line_cnt_q;
        frame_cnt_nxt = frame_cnt_q;
        fs_nxt        = 1'b0;
        fd_nxt        = 1'b0;
        ld_nxt        = 1'b0;
        set_line      = 1'b0;
        set_frame     = 1'b0;
        lines_at_end  = line_cnt_q;
        pix_inc       = (&pix_q) ? pix_q : pix_q + PIX_W'(1);
        line_inc      = (&line_cnt_q) ? line_cnt_q : line_cnt_q + LINE_W'(1);
        case (state_q)
            S_IDLE: begin
                if (fv_rise && capture_en) begin
                    state_nxt    = S_FOT;
                    fs_nxt       = 1'b1;
                    line_cnt_nxt = '0;
                end
            end
            S_FOT, S_ROT: begin
                // Frame end takes priority over a coincident line start.
                if (fv_fall) begin
                    state_nxt = S_IDLE;
                    fd_nxt    = 1'b1;
                end else if (lv_rise) begin
                    state_nxt = S_WR_EN;
                    pix_nxt   = '0;
                end
            end
            S_WR_EN: begin
                pix_nxt = pix_inc;
                // A frame end while a line is open also closes that line.
                if (lv_fall || fv_fall) begin
                    state_nxt    = S_ROT;
                    ld_nxt       = 1'b1;
                    line_pix_nxt = pix_inc;
                    line_cnt_nxt = line_inc;
                    lines_at_end = line_inc;
                    set_line     = (pix_inc != PIX_W'(EXP_PIX));
                end
                if (fv_fall) begin
                    state_nxt = S_IDLE;
                    fd_nxt    = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (fd_nxt) begin
            frame_cnt_nxt = frame_cnt_q + FCNT_W'(1);
            set_frame     = (lines_at_end != LINE_W'(EXP_LINES));
        end
    end

    // Registered outputs, counters and sticky errors (set beats clear).
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pix_q       <= '0;
            line_pix_q  <= '0;
            line_cnt_q  <= '0;
            frame_cnt_q <= '0;
            fs_q        <= 1'b0;
            fd_q        <= 1'b0;
            ld_q        <= 1'b0;
            err_line_q  <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            pix_q       <= pix_nxt;
            line_pix_q  <= line_pix_nxt;
            line_cnt_q  <= line_cnt_nxt;
            frame_cnt_q <= frame_cnt_nxt;
            fs_q        <= fs_nxt;
            fd_q        <= fd_nxt;
            ld_q        <= ld_nxt;
            err_line_q  <= (err_line_q & ~err_clr) | set_line;
            err_frame_q <= (err_frame_q & ~err_clr) | set_frame;
        end
    end

    assign state         = state_q;
    assign frame_start   = fs_q;
    assign frame_done    = fd_q;
    assign line_done     = ld_q;
    assign line_pix      = line_pix_q;
    assign line_cnt      = line_cnt_q;
    assign frame_cnt     = frame_cnt_q;
    assign err_line_len  = err_line_q;
    assign err_frame_len = err_frame_q;
endmodule

// File: tb/tb_daq_frame_ctrl.sv
// tb/tb_daq_frame_ctrl.sv - directed self-checking bench for daq_frame_ctrl
module tb_daq_frame_ctrl;
    // 608 px per line; frame height reduced to keep the full-frame run short.
    localparam int EXP_PIX   = 608;
    localparam int EXP_LINES = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        capture_en = 1'b0;
    logic        frame_vaild = 1'b0;
    logic        line_vaild = 1'b0;
    logic        err_clr = 1'b0;
    logic [2:0]  state;
    logic        frame_start, frame_done, line_done;
    logic [11:0] line_pix;
    logic [10:0] line_cnt;
    logic [15:0] frame_cnt;
    logic        err_line_len, err_frame_len;

    int n_vec = 0;
    int n_err = 0;
    int wr_cycles = 0;
    int ld_seen = 0;
    int fd_seen = 0;
    int fs_seen = 0;

    daq_frame_ctrl #(
        .PIX_W     (12),
        .LINE_W    (11),
        .FCNT_W    (16),
        .EXP_PIX   (EXP_PIX),
        .EXP_LINES (EXP_LINES)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .capture_en    (capture_en),
        .frame_vaild   (frame_vaild),
        .line_vaild    (line_vaild),
        .err_clr       (err_clr),
        .state         (state),
        .frame_start   (frame_start),
        .frame_done    (frame_done),
        .line_done     (line_done),
        .line_pix      (line_pix),
        .line_cnt      (line_cnt),
        .frame_cnt     (frame_cnt),
        .err_line_len  (err_line_len),
        .err_frame_len (err_frame_len)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (state == 3'b010) wr_cycles++;
        if (line_done)   ld_seen++;
        if (frame_done)  fd_seen++;
        if (frame_start) fs_seen++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_line(input int npix);
        line_vaild = 1'b1;
        step(npix);
        line_vaild = 1'b0;
        step(2);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        step(2);
        n_vec++; if (state !== 3'b000) begin n_err++; $display("FAIL rst_state got=%b exp=000", state); end
        n_vec++; if (line_cnt !== 11'd0) begin n_err++; $display("FAIL rst_line_cnt got=%0d exp=0", line_cnt); end
        n_vec++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL rst_frame_cnt got=%0d exp=0", frame_cnt); end
        n_vec++; if ({err_line_len, err_frame_len} !== 2'b00) begin n_err++; $display("FAIL rst_errs got=%b%b exp=00", err_line_len, err_frame_len); end
        n_vec++; if ({frame_start, frame_done, line_done} !== 3'b000) begin n_err++; $display("FAIL rst_pulses got=%b%b%b exp=000", frame_start, frame_done, line_done); end
        sys_rst = 1'b0;
        step(1);
    endtask

    task automatic test_reset_mid_frame();
        int fd0, fs0;
        capture_en  = 1'b1;
        frame_vaild = 1'b1;
        step(2);
        line_vaild = 1'b1;
        step(3);
        n_vec++; if (state !== 3'b010) begin n_err++; $display("FAIL mid_wren got=%b exp=010", state); end
        fd0 = fd_seen;
        fs0 = fs_seen;
        sys_rst = 1'b1;
        #2;
        n_vec++; if (state !== 3'b000) begin n_err++; $display("FAIL async_rst_state got=%b exp=000", state); end
        n_vec++; if (line_cnt !== 11'd0) begin n_err++; $display("FAIL async_rst_line_cnt got=%0d exp=0", line_cnt); end
        step(2);
        sys_rst = 1'b0;
        step(5);
        n_vec++; if (state !== 3'b000) begin n_err++; $display("FAIL no_midframe_entry got=%b exp=000", state); end
        n_vec++; if (fs_seen !== fs0) begin n_err++; $display("FAIL no_midframe_start got=%0d exp=%0d", fs_seen, fs0); end
        line_vaild  = 1'b0;
        frame_vaild = 1'b0;
        step(2);
        n_vec++; if (fd_seen !== fd0) begin n_err++; $display("FAIL rst_no_frame_done got=%0d exp=%0d", fd_seen, fd0); end
        n_vec++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL rst_discard_frame got=%0d exp=0", frame_cnt); end
        frame_vaild = 1'b1;
        step(1);
        n_vec++; if (state !== 3'b001) begin n_err++; $display("FAIL new_rise_fot got=%b exp=001", state); end
        frame_vaild = 1'b0;
        step(2);
        sys_rst = 1'b1;
        step(1);
        sys_rst = 1'b0;
        step(1);
    endtask

    task automatic test_frame_3x608();
        int ld0;
        ld0 = ld_seen;
        capture_en  = 1'b1;
        frame_vaild = 1'b1;
        step(1);
        n_vec++; if (state !== 3'b001) begin n_err++; $display("FAIL f3_fot got=%b exp=001", state); end
        n_vec++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL f3_frame_start got=%b exp=1", frame_start); end
        step(1);
        for (int l = 0; l < 3; l++) begin
            line_vaild = 1'b1;
            step(1);
            n_vec++; if (state !== 3'b010) begin n_err++; $display("FAIL f3_wren line=%0d got=%b exp=010", l, state); end
            step(607);
            line_vaild = 1'b0;
            step(1);
            n_vec++; if (state !== 3'b100) begin n_err++; $display("FAIL f3_rot line=%0d got=%b exp=100", l, state); end
            n_vec++; if (line_done !== 1'b1) begin n_err++; $display("FAIL f3_line_done line=%0d got=%b exp=1", l, line_done); end
            n_vec++; if (line_pix !== 12'd608) begin n_err++; $display("FAIL f3_line_pix line=%0d got=%0d exp=608", l, line_pix); end
            step(1);
        end
        frame_vaild = 1'b0;
        step(1);
        n_vec++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL f3_frame_done got=%b exp=1", frame_done); end
        n_vec++; if (state !== 3'b000) begin n_err++; $display("FAIL f3_idle got=%b exp=000", state); end
        n_vec++; if (err_frame_len !== 1'b1) begin n_err++; $display("FAIL f3_err_frame got=%b exp=1", err_frame_len); end
        n_vec++; if (err_line_len !== 1'b0) begin n_err++; $display("FAIL f3_err_line got=%b exp=0", err_line_len); end
        n_vec++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL f3_frame_cnt got=%0d exp=1", frame_cnt); end
        n_vec++; if (line_cnt !== 11'd3) begin n_err++; $display("FAIL f3_line_cnt got=%0d exp=3", line_cnt); end
        n_vec++; if (ld_seen - ld0 !== 3) begin n_err++; $display("FAIL f3_line_done_count got=%0d exp=3", ld_seen - ld0); end
        step(1);
    endtask

    task automatic test_short_line();
        pulse_clr();
        n_vec++; if (err_frame_len !== 1'b0) begin n_err++; $display("FAIL sl_clr_frame got=%b exp=0", err_frame_len); end
        frame_vaild = 1'b1;
        step(2);
        line_vaild = 1'b1;
        step(607);
        line_vaild = 1'b0;
        step(1);
        n_vec++; if (line_pix !== 12'd607) begin n_err++; $display("FAIL sl_line_pix got=%0d exp=607", line_pix); end
        n_vec++; if (err_line_len !== 1'b1) begin n_err++; $display("FAIL sl_err_line got=%b exp=1", err_line_len); end
        step(1);
        frame_vaild = 1'b0;
        step(2);
        pulse_clr();
        n_vec++; if ({err_line_len, err_frame_len} !== 2'b00) begin n_err++; $display("FAIL sl_clr_both got=%b%b exp=00", err_line_len, err_frame_len); end
        frame_vaild = 1'b1;
        step(2);
        line_vaild = 1'b1;
        step(607);
        line_vaild = 1'b0;
        err_clr    = 1'b1;
        step(1);
        err_clr = 1'b0;
        n_vec++; if (line_done !== 1'b1) begin n_err++; $display("FAIL sl_coinc_line_done got=%b exp=1", line_done); end
        n_vec++; if (err_line_len !== 1'b1) begin n_err++; $display("FAIL sl_set_wins got=%b exp=1", err_line_len); end
        step(1);
        frame_vaild = 1'b0;
        step(2);
    endtask

    task automatic test_capture_en();
        int fs0;
        capture_en = 1'b0;
        fs0 = fs_seen;
        frame_vaild = 1'b1;
        step(2);
        capture_en = 1'b1;
        step(3);
        n_vec++; if (state !== 3'b000) begin n_err++; $display("FAIL ce_late_state got=%b exp=000", state); end
        n_vec++; if (fs_seen !== fs0) begin n_err++; $display("FAIL ce_late_start got=%0d exp=%0d", fs_seen, fs0); end
        frame_vaild = 1'b0;
        step(2);
        frame_vaild = 1'b1;
        step(1);
        n_vec++; if ({state, frame_start} !== 4'b0011) begin n_err++; $display("FAIL ce_next_rise got=%b/%b exp=001/1", state, frame_start); end
        step(1);
        send_line(4);
        capture_en = 1'b0;
        send_line(4);
        frame_vaild = 1'b0;
        step(1);
        n_vec++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL ce_drop_done got=%b exp=1", frame_done); end
        n_vec++; if (frame_cnt !== 16'd4) begin n_err++; $display("FAIL ce_drop_frame_cnt got=%0d exp=4", frame_cnt); end
        n_vec++; if (line_cnt !== 11'd2) begin n_err++; $display("FAIL ce_drop_line_cnt got=%0d exp=2", line_cnt); end
        step(1);
        frame_vaild = 1'b1;
        step(3);
        n_vec++; if (state !== 3'b000) begin n_err++; $display("FAIL ce_off_ignored got=%b exp=000", state); end
        n_vec++; if (fs_seen !== fs0 + 1) begin n_err++; $display("FAIL ce_off_start got=%0d exp=%0d", fs_seen, fs0 + 1); end
        n_vec++; if (line_cnt !== 11'd2) begin n_err++; $display("FAIL ce_line_cnt_hold got=%0d exp=2", line_cnt); end
        frame_vaild = 1'b0;
        step(2);
    endtask

    task automatic test_simul_fall();
        capture_en = 1'b1;
        pulse_clr();
        frame_vaild = 1'b1;
        step(2);
        send_line(608);
        line_vaild = 1'b1;
        step(608);
        n_vec++; if (state !== 3'b010) begin n_err++; $display("FAIL sf_pre got=%b exp=010", state); end
        line_vaild  = 1'b0;
        frame_vaild = 1'b0;
        step(1);
        n_vec++; if ({line_done, frame_done} !== 2'b11) begin n_err++; $display("FAIL sf_pulses got=%b%b exp=11", line_done, frame_done); end
        n_vec++; if (line_cnt !== 11'd2) begin n_err++; $display("FAIL sf_line_cnt got=%0d exp=2", line_cnt); end
        n_vec++; if (state !== 3'b000) begin n_err++; $display("FAIL sf_state got=%b exp=000", state); end
        n_vec++; if (line_pix !== 12'd608) begin n_err++; $display("FAIL sf_line_pix got=%0d exp=608", line_pix); end
        n_vec++; if (frame_cnt !== 16'd5) begin n_err++; $display("FAIL sf_frame_cnt got=%0d exp=5", frame_cnt); end
        n_vec++; if (err_frame_len !== 1'b1) begin n_err++; $display("FAIL sf_err_frame got=%b exp=1", err_frame_len); end
        step(2);
    endtask

    task automatic test_full_frame();
        int wr0, ld0, fd0, lag_bad;
        pulse_clr();
        wr0 = wr_cycles;
        ld0 = ld_seen;
        fd0 = fd_seen;
        lag_bad = 0;
        frame_vaild = 1'b1;
        step(2);
        for (int l = 0; l < EXP_LINES; l++) begin
            line_vaild = 1'b1;
            if (state == 3'b010) lag_bad++;
            step(1);
            if (state != 3'b010) lag_bad++;
            step(EXP_PIX - 1);
            line_vaild = 1'b0;
            if (state != 3'b010) lag_bad++;
            step(1);
            if (state != 3'b100) lag_bad++;
            step(1);
        end
        frame_vaild = 1'b0;
        step(2);
        n_vec++; if (lag_bad !== 0) begin n_err++; $display("FAIL ff_lag got=%0d exp=0", lag_bad); end
        n_vec++; if (wr_cycles - wr0 !== EXP_PIX * EXP_LINES) begin n_err++; $display("FAIL ff_wren_cycles got=%0d exp=%0d", wr_cycles - wr0, EXP_PIX * EXP_LINES); end
        n_vec++; if (line_cnt !== 11'(EXP_LINES)) begin n_err++; $display("FAIL ff_line_cnt got=%0d exp=%0d", line_cnt, EXP_LINES); end
        n_vec++; if ({err_line_len, err_frame_len} !== 2'b00) begin n_err++; $display("FAIL ff_errs got=%b%b exp=00", err_line_len, err_frame_len); end
        n_vec++; if (frame_cnt !== 16'd6) begin n_err++; $display("FAIL ff_frame_cnt got=%0d exp=6", frame_cnt); end
        n_vec++; if (ld_seen - ld0 !== EXP_LINES) begin n_err++; $display("FAIL ff_line_dones got=%0d exp=%0d", ld_seen - ld0, EXP_LINES); end
        n_vec++; if (fd_seen - fd0 !== 1) begin n_err++; $display("FAIL ff_frame_dones got=%0d exp=1", fd_seen - fd0); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_frame();
        test_frame_3x608();
        test_short_line();
        test_capture_en();
        test_simul_fall();
        test_full_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
